fifo_stream_reader: RTL and testbench

Drain-side controller for the team's synchronous FIFO. It issues FIFO reads, absorbs the FIFO's one-cycle registered read latency, and presents words on a valid/ready output stream with an internal credit buffer. Sits between the FIFO read port and a downstream consumer. Supports enable/stop and a flush command.

---
 rtl/fifo_stream_reader.sv | 179 +++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drain-side controller for the synchronous FIFO: issues reads, absorbs the
// FIFO's one-cycle read latency and presents words on a valid/ready stream.
// Latency: read in cycle t gives the word on out_data in cycle t+2 at the earliest.
// Backpressure: reads are throttled by buffer occupancy, with no comb path from out_ready.
// Optional statistics counters are built when RD_STATS_EN is defined.
module fifo_stream_reader #(
   parameter int WIDTH     = 8,
   parameter int BUF_DEPTH = 4    // power of two, >= 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             drain_en,
   input  logic             flush,
   output logic             fifo_read_en,
   input  logic [WIDTH-1:0] fifo_read_data,
   input  logic             fifo_empty,
   input  logic             fifo_read_error,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             flush_done,
   output logic             err,
   output logic [15:0]      beat_count,
   output logic [15:0]      flush_drop_count
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             pending_q;
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] mem_q [BUF_DEPTH];
   logic             flush_done_q, flush_done_d;
   logic             err_q;

   logic             push;
   logic             pop;
   logic [CW-1:0]    occupancy;

   // Words already buffered plus the one in flight from the FIFO; reserving
   // space for the in-flight word is what keeps out_ready off the read path.
   assign occupancy = count_q + CW'(pending_q);

   assign out_valid  = (count_q != '0);
   assign out_data   = mem_q[rd_ptr_q];
   assign pop        = out_valid && out_ready;
   assign busy       = (state_q != S_IDLE) || (count_q != '0) || pending_q;
   assign flush_done = flush_done_q;
   assign err        = err_q;

   // Read request: throttled by buffer space while running, unconditional while flushing.
   always_comb begin
      fifo_read_en = 1'b0;
      case (state_q)
         S_RUN:   fifo_read_en = drain_en && !fifo_empty && (occupancy < CW'(BUF_DEPTH));
         S_FLUSH: fifo_read_en = !fifo_empty;
         default: fifo_read_en = 1'b0;
      endcase
   end

   // Next state; flush takes priority and flush_done is raised on FLUSH->IDLE.
   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      if (flush) begin
         state_d = S_FLUSH;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (drain_en) state_d = S_RUN;
            end
            S_RUN: begin
               // Stay until the in-flight word has landed so it is not stranded.
               if (!drain_en && !pending_q) state_d = S_IDLE;
            end
            S_FLUSH: begin
               if (fifo_empty && !pending_q) begin
                  state_d      = S_IDLE;
                  flush_done_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Buffer bookkeeping: a landing word is kept unless we are flushing; flush empties the buffer.
   always_comb begin
      push     = pending_q && (state_q != S_FLUSH) && !flush;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (!push && pop) count_d = count_q - CW'(1);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pending_q    <= 1'b0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         flush_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= fifo_read_en;
         count_q      <= count_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         flush_done_q <= flush_done_d;
         err_q        <= err_q | fifo_read_error;
      end
   end

   // Buffer storage; cleared on reset so out_data reads zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= fifo_read_data;
      end
   end

`ifdef RD_STATS_EN
   logic [15:0]   beat_q;
   logic [15:0]   drop_q;
   logic [CW-1:0] drop_inc;
   logic [16:0]   drop_sum;

   // Words thrown away this cycle: what is left in the buffer at flush entry
   // (minus a word the consumer takes on that same edge) plus any landing word.
   always_comb begin
      drop_inc = '0;
      if (flush)                   drop_inc = count_q - CW'(pop) + CW'(pending_q);
      else if (state_q == S_FLUSH) drop_inc = CW'(pending_q);
   end

   assign drop_sum = {1'b0, drop_q} + 17'(drop_inc);

   // Saturating beat and drop counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_q <= '0;
         drop_q <= '0;
      end else begin
         if (pop && (beat_q != 16'hFFFF)) beat_q <= beat_q + 16'd1;
         drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   assign beat_count       = beat_q;
   assign flush_drop_count = drop_q;
`else
   assign beat_count       = 16'd0;
   assign flush_drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model on the read side,
// scoreboard of expected words filled when the model FIFO is loaded.
module tb_fifo_stream_reader;

   logic        clk;
   logic        rst;
   logic        drain_en;
   logic        flush;
   logic        fifo_read_en;
   logic [7:0]  fifo_read_data;
   logic        fifo_empty;
   logic        fifo_read_error;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        busy;
   logic        flush_done;
   logic        err;
   logic [15:0] beat_count;
   logic [15:0] flush_drop_count;

   fifo_stream_reader #(.WIDTH(8), .BUF_DEPTH(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .drain_en         (drain_en),
      .flush            (flush),
      .fifo_read_en     (fifo_read_en),
      .fifo_read_data   (fifo_read_data),
      .fifo_empty       (fifo_empty),
      .fifo_read_error  (fifo_read_error),
      .out_valid        (out_valid),
      .out_data         (out_data),
      .out_ready        (out_ready),
      .busy             (busy),
      .flush_done       (flush_done),
      .err              (err),
      .beat_count       (beat_count),
      .flush_drop_count (flush_drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model of the synchronous FIFO: registered read data, error on empty read.
   logic [7:0] fmem [0:255];
   int         wr_idx = 0;
   int         rd_idx = 0;

   assign fifo_empty = (rd_idx == wr_idx);

   always @(posedge clk) begin
      if (fifo_read_en) begin
         if (rd_idx != wr_idx) begin
            fifo_read_data  <= fmem[rd_idx];
            rd_idx          <= rd_idx + 1;
            fifo_read_error <= 1'b0;
         end else begin
            fifo_read_error <= 1'b1;
         end
      end else begin
         fifo_read_error <= 1'b0;
      end
   end

   // Scoreboard and per-test observations.
   logic [7:0] exp_q [$];
   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   int rd_n, first_rd, last_rd;
   int hs_n, first_hs, last_hs;
   int vld_n, first_vld, fd_n;
   int beat_exp = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic clr();
      rd_n = 0; first_rd = -1; last_rd = -1;
      hs_n = 0; first_hs = -1; last_hs = -1;
      vld_n = 0; first_vld = -1; fd_n = 0;
   endtask

   task automatic load(input logic [7:0] w);
      fmem[wr_idx] = w;
      wr_idx++;
      exp_q.push_back(w);
   endtask

   // Sample the cycle's outputs (inputs already set), then advance to the next negedge.
   task automatic tick();
      #1;
      if (fifo_read_en) begin
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
         rd_n++;
      end
      if (out_valid) begin
         if (first_vld < 0) first_vld = cyc;
         vld_n++;
      end
      if (flush_done) fd_n++;
      if (out_valid && out_ready) begin
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
         hs_n++;
         beat_exp++;
         if (exp_q.size() == 0) check("spurious_beat", 32'(exp_q.size()), 32'd1);
         else                   check("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
      cyc++;
      @(negedge clk);
   endtask

   int remain;
   int budget;

   initial begin
      rst = 1'b1; drain_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_read_en", fifo_read_en, 0);
      check("rst_busy", busy, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_err", err, 0);
      check("rst_beat", beat_count, 0);
      check("rst_drop", flush_drop_count, 0);
      rst = 1'b1;
      @(negedge clk);

      // 1: basic drain of three words
      clr();
      load(8'h11); load(8'h22); load(8'h33);
      drain_en = 1'b1; out_ready = 1'b1;
      repeat (10) tick();
      check("t1_reads", rd_n, 3);
      check("t1_reads_consec", last_rd - first_rd, 2);
      check("t1_latency", first_vld - first_rd, 2);
      check("t1_beats", hs_n, 3);
      check("t1_beats_consec", last_hs - first_hs, 2);
      check("t1_sb_empty", exp_q.size(), 0);

      // 2: backpressure with eight words
      clr();
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) load(8'(i));
      repeat (12) tick();
      check("t2_stall_reads", rd_n, 4);
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_data", out_data, 8'h01);
      repeat (3) tick();
      check("t2_hold_data_later", out_data, 8'h01);
      check("t2_stall_reads_later", rd_n, 4);
      out_ready = 1'b1;
      budget = 0;
      while (exp_q.size() != 0 && budget < 40) begin tick(); budget++; end
      check("t2_beats", hs_n, 8);
      check("t2_beats_consec", last_hs - first_hs, 7);
      check("t2_sb_empty", exp_q.size(), 0);
      repeat (3) tick();

      // 3: empty FIFO
      clr();
      repeat (20) tick();
      check("t3_reads", rd_n, 0);
      check("t3_valid", vld_n, 0);
      check("t3_err", err, 0);

      // 4: flush with six words and a stalled consumer
      clr();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) load(8'h40 + 8'(i));
      budget = 0;
      while (rd_n < 4 && budget < 30) begin tick(); budget++; end
      repeat (3) tick();
      check("t4_reads_before_flush", rd_n, 4);
      flush = 1'b1; drain_en = 1'b0;
      exp_q.delete();
      tick();
      flush = 1'b0;
      check("t4_valid_after_flush", out_valid, 0);
      budget = 0;
      while (fd_n == 0 && budget < 30) begin tick(); budget++; end
      repeat (5) tick();
      check("t4_flush_done_once", fd_n, 1);
      check("t4_fifo_empty", fifo_empty, 1);
      check("t4_idle", busy, 0);
      check("t4_valid", out_valid, 0);
      check("t4_err", err, 0);
`ifdef RD_STATS_EN
      check("t4_drop_count", flush_drop_count, 6);
`else
      check("t4_drop_count", flush_drop_count, 0);
`endif

      // 5: asynchronous reset mid-stream
      clr();
      drain_en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) load(8'hA0 + 8'(i));
      repeat (5) tick();
      check("t5_pre_valid", out_valid, 1);
      check("t5_pre_read_en", fifo_read_en, 1);
      #2 rst = 1'b0;
      #1;
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_read_en", fifo_read_en, 0);
      check("t5_rst_busy", busy, 0);
      drain_en = 1'b0;
      beat_exp = 0;
      @(negedge clk);
      rst = 1'b1;
      // Words already taken out of the model FIFO were lost with the reset.
      exp_q.delete();
      for (int i = rd_idx; i < wr_idx; i++) exp_q.push_back(fmem[i]);
      remain = wr_idx - rd_idx;
      clr();
      repeat (5) tick();
      check("t5_no_reads_idle", rd_n, 0);
      drain_en = 1'b1;
      budget = 0;
      while (exp_q.size() != 0 && budget < 40) begin tick(); budget++; end
      check("t5_reads_after", rd_n, remain);
      check("t5_beats_after", hs_n, remain);
      repeat (3) tick();

      // 6: full-rate drain of sixteen words
      clr();
      for (int i = 0; i < 16; i++) load(8'hC0 + 8'(i));
      budget = 0;
      while (exp_q.size() != 0 && budget < 60) begin tick(); budget++; end
      check("t6_beats", hs_n, 16);
      check("t6_beats_consec", last_hs - first_hs, 15);
      check("t6_reads_consec", last_rd - first_rd, 15);
`ifdef RD_STATS_EN
      check("t6_beat_count", beat_count, 32'(beat_exp));
`else
      check("t6_beat_count", beat_count, 0);
`endif
      check("final_err", err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
